nios2_debug_cmd_bridge: RTL and testbench

//   Parametrised successor to the debug-slave sysclk stage. It takes the virtual-JTAG

---
 rtl/nios2_debug_pkg.sv | 16 +
 rtl/nios2_debug_cmd_bridge_if.sv | 36 +++
 rtl/nios2_debug_sync_edge.sv | 49 ++++
 rtl/nios2_debug_cmd_bridge.sv | 133 +++++++++++++
 tb/tb_nios2_debug_cmd_bridge.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_debug_pkg.sv
// Shared types and default widths for the Nios II debug command bridge.
//   debug_cmd_t : one captured data-register update (IR, shift data, action flag).
//   DBG_*       : default widths and the default take_action bit position.
package nios2_debug_pkg;

  localparam int unsigned DBG_DATA_W     = 38;
  localparam int unsigned DBG_IR_W       = 2;
  localparam int unsigned DBG_ACTION_BIT = 34;

  typedef struct packed {
    logic [DBG_IR_W-1:0]   ir;
    logic [DBG_DATA_W-1:0] data;
    logic                  take_action;
  } debug_cmd_t;

endpackage

// File: rtl/nios2_debug_cmd_bridge_if.sv
// Command handshake between the debug bridge (master) and the OCI/break logic (slave).
//   cmd_valid        master -> slave  head entry valid
//   cmd_ready        slave -> master  head entry accepted this cycle
//   cmd_ir           master -> slave  head entry IR value
//   cmd_data         master -> slave  head entry data (jdo)
//   cmd_take_action  master -> slave  head entry action flag
interface nios2_debug_cmd_bridge_if
  import nios2_debug_pkg::*;
#(
  parameter int unsigned DATA_W = DBG_DATA_W,
  parameter int unsigned IR_W   = DBG_IR_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_take_action;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output cmd_data,
    output cmd_take_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  cmd_data,
    input  cmd_take_action,
    output cmd_ready
  );

endinterface

// File: rtl/nios2_debug_sync_edge.sv
// Synchroniser plus rising-edge detector for one asynchronous level strobe.
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   async_in    in   asynchronous level from the TCK domain
//   rise_pulse  out  registered one-cycle pulse, SYNC_STAGES+1 edges after the rise
module nios2_debug_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  localparam int unsigned ARM_CNT = SYNC_STAGES + 1;
  localparam int unsigned CNT_W   = $clog2(ARM_CNT + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_arm_cnt;
  logic                   w_sync_out;
  logic                   w_armed;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Edge detection stays disabled until the chain and r_prev have refilled after
  // reset, so a strobe already high through reset never looks like a fresh rise.
  assign w_armed = (r_arm_cnt == CNT_W'(ARM_CNT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_pulse   <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev  <= w_sync_out;
      r_pulse <= w_armed & w_sync_out & ~r_prev;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + CNT_W'(1);
      end
    end
  end

  assign rise_pulse = r_pulse;

endmodule

// File: rtl/nios2_debug_cmd_bridge.sv
// Debug command bridge: synchronises the virtual-JTAG update strobes into clk and
// queues every data-register update as a command for the OCI/break logic.
//   clk             in   system clock
//   reset           in   synchronous active-high reset
//   vs_udr          in   async Update-DR level (TCK domain)
//   vs_uir          in   async Update-IR level (TCK domain)
//   ir_in           in   quasi-static IR from the TCK domain
//   sr              in   quasi-static shift register from the TCK domain
//   cmd             if   master side of the command valid/ready handshake
//   ir_update       out  one-cycle pulse per synchronised vs_uir rise
//   fifo_level      out  number of queued commands
//   overflow        out  sticky: an update was dropped on a full queue
//   clear_overflow  in   clears overflow (a simultaneous drop wins)
module nios2_debug_cmd_bridge
  import nios2_debug_pkg::*;
#(
  parameter  int unsigned DATA_W      = DBG_DATA_W,
  parameter  int unsigned IR_W        = DBG_IR_W,
  parameter  int unsigned ACTION_BIT  = DBG_ACTION_BIT,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vs_udr,
  input  logic                            vs_uir,
  input  logic [IR_W-1:0]                 ir_in,
  input  logic [DATA_W-1:0]               sr,
  nios2_debug_cmd_bridge_if.master        cmd,
  output logic                            ir_update,
  output logic [LVL_W-1:0]                fifo_level,
  output logic                            overflow,
  input  logic                            clear_overflow
);

  localparam int unsigned IDX_W = LVL_W - 1;

  logic             w_udr_pulse;
  logic             w_uir_pulse;

  debug_cmd_t       r_mem [FIFO_DEPTH];
  debug_cmd_t       r_head;
  debug_cmd_t       w_new;
  debug_cmd_t       w_head_nxt;
  logic [LVL_W-1:0] r_wptr;
  logic [LVL_W-1:0] r_rptr;
  logic [LVL_W-1:0] w_wptr_nxt;
  logic [LVL_W-1:0] w_rptr_nxt;
  logic [LVL_W-1:0] w_level_nxt;
  logic             r_valid;
  logic             r_overflow;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk        (clk),
    .reset      (reset),
    .async_in   (vs_udr),
    .rise_pulse (w_udr_pulse)
  );

  nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk        (clk),
    .reset      (reset),
    .async_in   (vs_uir),
    .rise_pulse (w_uir_pulse)
  );

  assign w_full = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                  (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
  assign w_pop  = r_valid & cmd.cmd_ready;
  // A full queue still takes the push when the head leaves in the same cycle.
  assign w_push = w_udr_pulse & (~w_full | w_pop);
  assign w_drop = w_udr_pulse & w_full & ~w_pop;

  // sr/ir_in are held by the TCK side well past Update-DR, so sampling them on the
  // synchronised pulse needs no further capture stage.
  assign w_new = '{ir: ir_in, data: sr, take_action: sr[ACTION_BIT]};

  // Head output is registered, so the next head is selected ahead of the edge;
  // when the entry being written becomes the head it bypasses the storage array.
  always_comb begin
    w_wptr_nxt  = r_wptr + LVL_W'(w_push);
    w_rptr_nxt  = r_rptr + LVL_W'(w_pop);
    w_level_nxt = w_wptr_nxt - w_rptr_nxt;
    w_head_nxt  = '0;
    if (w_level_nxt != '0) begin
      if (w_push && (w_rptr_nxt[IDX_W-1:0] == r_wptr[IDX_W-1:0])) begin
        w_head_nxt = w_new;
      end else begin
        w_head_nxt = r_mem[w_rptr_nxt[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[IDX_W-1:0]] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_valid <= (w_level_nxt != '0);
      r_head  <= w_head_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign cmd.cmd_valid       = r_valid;
  assign cmd.cmd_ir          = r_head.ir;
  assign cmd.cmd_data        = r_head.data;
  assign cmd.cmd_take_action = r_head.take_action;
  assign ir_update           = w_uir_pulse;
  assign fifo_level          = r_wptr - r_rptr;
  assign overflow            = r_overflow;

endmodule

// File: tb/tb_nios2_debug_cmd_bridge.sv
// Self-checking bench for nios2_debug_cmd_bridge (SYNC_STAGES=2, FIFO_DEPTH=4).
module tb_nios2_debug_cmd_bridge;
  import nios2_debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs_udr = 1'b0;
  logic        vs_uir = 1'b0;
  logic        clear_overflow = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        ir_update;
  logic        overflow;
  logic [2:0]  fifo_level;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  debug_cmd_t  q_exp[$];

  nios2_debug_cmd_bridge_if #(.DATA_W(38), .IR_W(2)) cmd_if ();

  nios2_debug_cmd_bridge #(
    .DATA_W(38), .IR_W(2), .ACTION_BIT(34), .SYNC_STAGES(2), .FIFO_DEPTH(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd            (cmd_if.master),
    .ir_update      (ir_update),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One host update: rise, hold past the push edge, fall, let the chain clear.
  task automatic do_update(input logic [1:0] ir, input logic [37:0] d, input bit accept);
    debug_cmd_t e;
    ir_in = ir; sr = d; vs_udr = 1'b1;
    if (accept) begin
      e.ir = ir; e.data = d; e.take_action = d[34];
      q_exp.push_back(e);
    end
    step(4);
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic drain(input string name);
    int unsigned budget = 60;
    debug_cmd_t  e;
    debug_cmd_t  act;
    cmd_if.cmd_ready = 1'b1;
    while (budget > 0) begin
      act = {cmd_if.cmd_ir, cmd_if.cmd_data, cmd_if.cmd_take_action};
      if (cmd_if.cmd_valid === 1'b1) begin
        n_checks++;
        if (q_exp.size() == 0) begin
          $display("FAIL %s_unexpected: got entry %h, required none", name, act);
          break;
        end
        e = q_exp.pop_front();
        if (act !== e) $display("FAIL %s_pop: got %h, required %h", name, act, e);
        else n_pass++;
      end else if (q_exp.size() == 0) begin
        break;
      end
      step(1);
      budget--;
    end
    cmd_if.cmd_ready = 1'b0;
    n_checks++;
    if (q_exp.size() != 0) begin
      $display("FAIL %s_timeout: %0d entries outstanding, required 0", name, q_exp.size());
      q_exp.delete();
    end else n_pass++;
    n_checks++;
    if ({cmd_if.cmd_valid, fifo_level} !== 4'b0)
      $display("FAIL %s_empty: valid=%b level=%0d, required 0/0", name, cmd_if.cmd_valid, fifo_level);
    else n_pass++;
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    reset = 1'b1; vs_udr = 1'b1;
    step(3);
    n_checks++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_ir, cmd_if.cmd_data, cmd_if.cmd_take_action} !== 42'b0)
      $display("FAIL reset_cmd: got %b/%h/%h/%b, required all 0", cmd_if.cmd_valid,
               cmd_if.cmd_ir, cmd_if.cmd_data, cmd_if.cmd_take_action);
    else n_pass++;
    n_checks++;
    if ({ir_update, fifo_level, overflow} !== 5'b0)
      $display("FAIL reset_status: ir_update=%b level=%0d overflow=%b, required 0",
               ir_update, fifo_level, overflow);
    else n_pass++;
    reset = 1'b0;
    repeat (10) begin
      step(1);
      if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== 3'd0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL reset_held_udr: got push=%b, required 0", seen);
    else n_pass++;
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic test_single();
    debug_cmd_t e;
    ir_in = 2'b01; sr = 38'h04_0000_1234; vs_udr = 1'b1;
    e.ir = 2'b01; e.data = 38'h04_0000_1234; e.take_action = 1'b1;
    q_exp.push_back(e);
    step(3);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b0) $display("FAIL single_early: valid=%b at edge 3, required 0", cmd_if.cmd_valid);
    else n_pass++;
    step(1);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b1) $display("FAIL single_valid: valid=%b at edge 4, required 1", cmd_if.cmd_valid);
    else n_pass++;
    n_checks++;
    if (cmd_if.cmd_ir !== 2'd1 || cmd_if.cmd_data !== 38'h04_0000_1234 || cmd_if.cmd_take_action !== 1'b1)
      $display("FAIL single_entry: got %h/%h/%b, required 1/0400001234/1",
               cmd_if.cmd_ir, cmd_if.cmd_data, cmd_if.cmd_take_action);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 3'd1) $display("FAIL single_level: got %0d, required 1", fifo_level);
    else n_pass++;
    vs_udr = 1'b0;
    step(4);
    drain("single");
  endtask

  task automatic test_burst();
    for (int i = 1; i <= 5; i++) do_update(i[1:0], 38'(i), i <= 4);
    n_checks++;
    if (fifo_level !== 3'd4) $display("FAIL burst_level: got %0d, required 4", fifo_level);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL burst_overflow: got %b, required 1", overflow);
    else n_pass++;
    drain("burst");
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL burst_clear: got %b, required 0", overflow);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    debug_cmd_t e;
    debug_cmd_t act;
    for (int i = 0; i < 4; i++)
      do_update(i[1:0], 38'h10 + 38'(i) + (i[0] ? 38'h04_0000_0000 : 38'h0), 1'b1);
    n_checks++;
    if (fifo_level !== 3'd4) $display("FAIL full_fill: got %0d, required 4", fifo_level);
    else n_pass++;
    ir_in = 2'd3; sr = 38'h04_0000_0014; vs_udr = 1'b1;
    step(3);
    // Pulse cycle: the head leaves while the new entry is pushed.
    cmd_if.cmd_ready = 1'b1;
    e = q_exp.pop_front();
    act = {cmd_if.cmd_ir, cmd_if.cmd_data, cmd_if.cmd_take_action};
    n_checks++;
    if (act !== e) $display("FAIL full_pop: got %h, required %h", act, e);
    else n_pass++;
    e.ir = 2'd3; e.data = 38'h04_0000_0014; e.take_action = 1'b1;
    q_exp.push_back(e);
    step(1);
    cmd_if.cmd_ready = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd4) $display("FAIL full_level: got %0d, required 4", fifo_level);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL full_overflow: got %b, required 0", overflow);
    else n_pass++;
    vs_udr = 1'b0;
    step(4);
    drain("full");
  endtask

  task automatic test_uir();
    debug_cmd_t e;
    do_update(2'd2, 38'h2A, 1'b1);
    vs_uir = 1'b1;
    step(2);
    n_checks++;
    if (ir_update !== 1'b0) $display("FAIL uir_early: got %b, required 0", ir_update);
    else n_pass++;
    step(1);
    n_checks++;
    if (ir_update !== 1'b1) $display("FAIL uir_pulse: got %b, required 1", ir_update);
    else n_pass++;
    step(1);
    n_checks++;
    if (ir_update !== 1'b0) $display("FAIL uir_width: got %b, required 0", ir_update);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 3'd1) $display("FAIL uir_level: got %0d, required 1", fifo_level);
    else n_pass++;
    vs_uir = 1'b0;
    step(4);
    ir_in = 2'd0; sr = 38'h3F_FFFF_FFFF; vs_udr = 1'b1; vs_uir = 1'b1;
    e.ir = 2'd0; e.data = 38'h3F_FFFF_FFFF; e.take_action = 1'b1;
    q_exp.push_back(e);
    step(3);
    n_checks++;
    if (ir_update !== 1'b1) $display("FAIL both_pulse: got %b, required 1", ir_update);
    else n_pass++;
    step(1);
    n_checks++;
    if ({ir_update, fifo_level} !== {1'b0, 3'd2})
      $display("FAIL both_push: ir_update=%b level=%0d, required 0/2", ir_update, fifo_level);
    else n_pass++;
    vs_udr = 1'b0; vs_uir = 1'b0;
    step(4);
    drain("uir");
  endtask

  task automatic test_overflow_clear();
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_start: got %b, required 0", overflow);
    else n_pass++;
    for (int i = 0; i < 4; i++) do_update(i[1:0], 38'h20 + 38'(i), 1'b1);
    ir_in = 2'd1; sr = 38'h99; vs_udr = 1'b1;
    step(3);
    clear_overflow = 1'b1;
    step(1);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b, required 1", overflow);
    else n_pass++;
    step(1);
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b, required 0", overflow);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d, required 4", fifo_level);
    else n_pass++;
    vs_udr = 1'b0;
    step(4);
    drain("ovf");
  endtask

  task automatic test_reset_flush();
    do_update(2'd1, 38'h55, 1'b1);
    do_update(2'd2, 38'h66, 1'b1);
    n_checks++;
    if (fifo_level !== 3'd2) $display("FAIL flush_fill: got %0d, required 2", fifo_level);
    else n_pass++;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    q_exp.delete();
    n_checks++;
    if ({cmd_if.cmd_valid, fifo_level, cmd_if.cmd_data} !== 42'b0)
      $display("FAIL flush_state: valid=%b level=%0d data=%h, required 0/0/0",
               cmd_if.cmd_valid, fifo_level, cmd_if.cmd_data);
    else n_pass++;
    step(4);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b0) $display("FAIL flush_after: valid=%b, required 0", cmd_if.cmd_valid);
    else n_pass++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    cmd_if.cmd_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_full_push_pop();
    test_uir();
    test_overflow_clear();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
